// File: rtl/mdr_mem_ctrl.sv
// Memory data register with byte/half/word lane steering and a timed
// request/acknowledge handshake towards data memory.
module mdr_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [DATA_W-1:0]   busmuxout,
  input  logic                mdrin,
  input  logic                rd_start,
  input  logic                wr_start,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [1:0]          addr_lo,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   q,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int NB = DATA_W / 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;
  localparam logic [1:0] S_FINISH  = 2'd3;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [1:0]        state;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [1:0]        addr_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  logic              start_illegal;
  logic [NB-1:0]     start_be;
  logic [DATA_W-1:0] start_wdata;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] rd_ext;

  assign cnt_next = cnt + 1'b1;

  // Alignment rules and lane pattern are decided from the raw start inputs,
  // which are the same values that get latched on the accepting edge.
  always_comb begin
    start_illegal = 1'b0;
    start_be      = '0;
    start_wdata   = q;
    case (size)
      2'b00: begin
        start_be[3:0] = 4'b0001 << addr_lo;
        start_wdata   = {NB{q[7:0]}};
      end
      2'b01: begin
        start_illegal = addr_lo[0];
        start_be[3:0] = addr_lo[1] ? 4'b1100 : 4'b0011;
        start_wdata   = {(NB/2){q[15:0]}};
      end
      2'b10: begin
        start_illegal = (addr_lo != 2'b00);
        start_be[3:0] = 4'b1111;
      end
      default: start_illegal = 1'b1;
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (addr_q)
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      2'd3:    rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   rd_ext = {{(DATA_W-8){sext_q & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{(DATA_W-16){sext_q & rd_half[15]}}, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= S_IDLE;
      q         <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_be    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      addr_q    <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_start || wr_start) begin
            size_q <= size;
            sext_q <= sign_ext;
            addr_q <= addr_lo;
            err    <= 1'b0;
            busy   <= 1'b1;
            if (start_illegal) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= ~rd_start;
              mem_be    <= start_be;
              mem_wdata <= start_wdata;
              cnt       <= '0;
              state     <= rd_start ? S_RD_WAIT : S_WR_WAIT;
            end
          end else if (mdrin) begin
            q <= busmuxout;
          end
        end
        // An ack in the final allowed cycle wins over the timeout.
        S_RD_WAIT, S_WR_WAIT: begin
          cnt <= cnt_next;
          if (mem_ack) begin
            if (state == S_RD_WAIT) q <= rd_ext;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            state   <= S_FINISH;
          end else if (cnt_next == TIMEOUT_CNT) begin
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            state   <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Scoreboard bench for mdr_mem_ctrl: a reference model predicts each
// transaction's outcome and a negedge monitor checks it at the done pulse.
module tb_mdr_mem_ctrl;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic [31:0] q;
    logic        err;
    int          req_cycles;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] busmuxout = '0;
  logic        mdrin = 1'b0;
  logic        rd_start = 1'b0;
  logic        wr_start = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [1:0]  addr_lo = 2'b00;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] q;
  logic        busy;
  logic        done;
  logic        err;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [31:0] model_q = '0;

  int          ack_delay = 0;
  logic [31:0] cur_rdata = '0;
  logic        force_ack = 1'b0;
  int          req_age = 0;

  mdr_mem_ctrl #(.DATA_W(32), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clock(clock), .clear(clear), .busmuxout(busmuxout), .mdrin(mdrin),
    .rd_start(rd_start), .wr_start(wr_start), .size(size), .sign_ext(sign_ext),
    .addr_lo(addr_lo), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .q(q), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Memory acknowledges in the (ack_delay+1)-th cycle of a request.
  always @(negedge clock) begin
    if (mem_req) req_age++;
    else req_age = 0;
    mem_ack   = (mem_req && req_age == ack_delay + 1) || force_ack;
    mem_rdata = cur_rdata;
  end

  int          mon_req = 0;
  logic        mon_prev_req = 1'b0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_wd = '0;

  always @(negedge clock) begin
    exp_t e;
    if (mem_req && !mon_prev_req) begin
      cap_be = mem_be;
      cap_we = mem_we;
      cap_wd = mem_wdata;
    end else if (mem_req) begin
      checkOutput("be_stable", {28'd0, mem_be}, {28'd0, cap_be});
      checkOutput("wdata_stable", mem_wdata, cap_wd);
    end
    if (mem_req) mon_req++;
    mon_prev_req = mem_req;
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("q", q, e.q);
        checkOutput("err", {31'd0, err}, {31'd0, e.err});
        checkOutput("req_cycles", mon_req, e.req_cycles);
        if (e.req_cycles > 0) begin
          checkOutput("be", {28'd0, cap_be}, {28'd0, e.be});
          checkOutput("we", {31'd0, cap_we}, {31'd0, e.we});
          if (e.we) checkOutput("wdata", cap_wd, e.wdata);
        end
      end
      mon_req = 0;
    end else if (!busy) begin
      mon_req = 0;
    end
  end

  task automatic predict(input bit rd, input logic [1:0] sz, input bit sx,
                         input logic [1:0] al, input logic [31:0] rdata, input int d);
    exp_t e;
    bit legal;
    logic [31:0] v;
    legal = (sz == 0) || (sz == 1 && al % 2 == 0) || (sz == 2 && al == 0);
    e.we = !rd;
    e.be = (sz == 0) ? 4'(1 << al) : (sz == 1) ? ((al >= 2) ? 4'hC : 4'h3) : 4'hF;
    e.wdata = (sz == 0) ? (model_q & 32'hFF) * 32'h01010101 :
              (sz == 1) ? (model_q & 32'hFFFF) * 32'h00010001 : model_q;
    if (!legal) begin
      e.err = 1'b1;
      e.req_cycles = 0;
    end else if (d >= TIMEOUT) begin
      e.err = 1'b1;
      e.req_cycles = TIMEOUT;
    end else begin
      e.err = 1'b0;
      e.req_cycles = d + 1;
      if (rd) begin
        v = rdata >> (8 * al);
        if (sz == 0) begin
          v = v & 32'hFF;
          if (sx && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 1) begin
          v = v & 32'hFFFF;
          if (sx && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        model_q = v;
      end
    end
    e.q = model_q;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                               input logic [1:0] al, input logic [31:0] rdata, input int d);
    int guard;
    @(negedge clock);
    ack_delay = d;
    cur_rdata = rdata;
    rd_start  = rd;
    wr_start  = wr;
    size      = sz;
    sign_ext  = sx;
    addr_lo   = al;
    mdrin     = $urandom_range(0, 1);
    busmuxout = $urandom;
    predict(rd, sz, sx, al, rdata, d);
    @(negedge clock);
    rd_start = 1'b0;
    wr_start = 1'b0;
    mdrin    = 1'b0;
    size     = 2'($urandom);
    sign_ext = 1'($urandom);
    addr_lo  = 2'($urandom);
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 40) checkOutput("txn_hang", 32'd1, 32'd0);
  endtask

  task automatic loadMdr(input logic [31:0] v);
    @(negedge clock);
    mdrin = 1'b1;
    busmuxout = v;
    @(negedge clock);
    mdrin = 1'b0;
    model_q = v;
    checkOutput("mdrin_q", q, v);
    checkOutput("mdrin_busy", {31'd0, busy}, 32'd0);
    checkOutput("mdrin_req", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    int op, d;
    clear = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    checkOutput("rst_q", q, 32'd0);
    checkOutput("rst_flags", {27'd0, mem_req, mem_we, busy, done, err}, 32'd0);
    checkOutput("rst_be_wdata", {28'd0, mem_be} | mem_wdata, 32'd0);

    loadMdr(32'hDEADBEEF);
    applyStimulus(1, 0, 2'b10, 0, 2'b00, 32'h12345678, 3);
    applyStimulus(1, 0, 2'b00, 1, 2'b10, 32'h00A50000, 0);
    applyStimulus(1, 0, 2'b00, 0, 2'b10, 32'h00A50000, 1);
    loadMdr(32'h0000BEEF);
    applyStimulus(0, 1, 2'b01, 0, 2'b10, 32'hFFFFFFFF, 2);
    applyStimulus(1, 0, 2'b10, 0, 2'b01, 32'h11111111, 0);
    applyStimulus(1, 0, 2'b10, 0, 2'b00, 32'h22222222, 99);
    applyStimulus(1, 0, 2'b10, 0, 2'b00, 32'h33333333, TIMEOUT - 1);
    applyStimulus(1, 1, 2'b01, 1, 2'b00, 32'h0000F00D, 1);
    applyStimulus(0, 1, 2'b11, 0, 2'b00, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) loadMdr($urandom);
      op = $urandom_range(0, 2);
      d  = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) d = TIMEOUT - 1 + $urandom_range(0, 2);
      applyStimulus(op != 1, op != 0, 2'($urandom), 1'($urandom), 2'($urandom), $urandom, d);
    end

    // Clear in the middle of a read that memory never answers.
    @(negedge clock);
    ack_delay = 99;
    rd_start = 1'b1;
    size = 2'b10;
    addr_lo = 2'b00;
    @(negedge clock);
    rd_start = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("clr_pre_req", {31'd0, mem_req}, 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_q = '0;
    checkOutput("clr_req", {31'd0, mem_req}, 32'd0);
    checkOutput("clr_q", q, 32'd0);
    checkOutput("clr_busy_err", {30'd0, busy, err}, 32'd0);
    cur_rdata = 32'hCAFEF00D;
    force_ack = 1'b1;
    repeat (2) @(negedge clock);
    force_ack = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("late_ack_q", q, 32'd0);
    checkOutput("late_ack_flags", {29'd0, mem_req, busy, done}, 32'd0);

    checkOutput("sb_leftover", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mdr_mem_ctrl.md
Name: mdr_mem_ctrl

Overview:
- Parametrised memory data register that also sequences the handshake with data memory.
- Holds the CPU-side data word. It loads from the internal bus or from memory, and drives store data with byte-lane enables for byte, half and word accesses.
- Read data is lane-extracted and zero- or sign-extended before it is captured.
- Sits between the datapath bus and the memory/RAM interface, and is controlled by the control unit through single-cycle start strobes.

Parameters:
- DATA_W, 32, data word width; must be a multiple of 8 and at least 32.
- TIMEOUT, 15, maximum number of cycles to wait for mem_ack before aborting; must be at least 1.
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- busmuxout  in  DATA_W  internal bus value.
- mdrin  in  1  load busmuxout into q (IDLE only).
- rd_start  in  1  start memory read (1-cycle strobe).
- wr_start  in  1  start memory write (1-cycle strobe).
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  in  1  1 = sign-extend sub-word reads, 0 = zero-extend.
- addr_lo  in  2  low address bits for lane select; sampled at start.
- mem_rdata  in  DATA_W  memory read data.
- mem_ack  in  1  memory completion, valid while mem_req=1.
- mem_req  out  1  request to memory.
- mem_we  out  1  1 = write request.
- mem_wdata  out  DATA_W  store data.
- mem_be  out  DATA_W/8  byte enables.
- q  out  DATA_W  MDR contents, to the bus.
- busy  out  1  transaction in progress.
- done  out  1  1-cycle completion pulse.
- err  out  1  sticky error flag; cleared by clear or by the next accepted start.

Behaviour:
- Reset: when clear=1 at a clock edge, all of the following happen:
  - state returns to IDLE;
  - q, mem_req, mem_we, mem_wdata, mem_be, busy, done, err and the counter all go to 0.
  - clear has priority over every other input, including mid-transaction; mem_req drops on the next edge.
- All outputs are registered; none is combinational from an input.
- States: IDLE, RD_WAIT, WR_WAIT, FINISH.
- IDLE:
  - rd_start has priority over wr_start; if both are asserted, only the read is performed.
  - If rd_start or wr_start is accepted, latch size, sign_ext and addr_lo and clear err.
  - Alignment check on the latched values:
    - illegal cases: size=11; half with addr_lo[0]=1; word with addr_lo≠00;
    - on an illegal case, set err=1, issue no request and go to FINISH.
  - Otherwise set mem_req=1, set mem_we (0 for read, 1 for write), zero the counter and go to RD_WAIT or WR_WAIT.
  - Request latency: mem_req is high in the cycle after the start strobe.
  - mdrin=1 with no start: q <= busmuxout on that edge.
  - mdrin together with an accepted start: the start is taken and mdrin is ignored.
- Write data:
  - mem_wdata replicates the low sub-word of q across all lanes: byte→4 copies of q[7:0], half→2 copies of q[15:0], word→q.
  - mem_be for byte = one-hot lane addr_lo; for half = 0011 or 1100 according to addr_lo[1]; for word = all ones.
  - For DATA_W>32, lanes above 32 bits carry enable 0; word moves DATA_W bits.
  - mem_be for read = the same lane pattern.
  - mem_wdata and mem_be are held stable while mem_req=1.
- RD_WAIT / WR_WAIT:
  - mem_req stays high and the counter increments every cycle.
  - mem_ack=1 in RD_WAIT:
    - q <= extracted lane: byte = mem_rdata[8*addr_lo +: 8], half = the 16 bits selected by addr_lo[1], word = mem_rdata;
    - extended to DATA_W per the latched sign_ext.
  - mem_ack=1 in WR_WAIT: q is unchanged.
  - On ack: mem_req<=0, mem_we<=0, go to FINISH. Read latency = ack cycle + 1 until q is valid.
  - Timeout: if the counter reaches TIMEOUT with no ack, set err=1, drop mem_req and go to FINISH; q is unchanged.
  - An ack arriving in the same cycle as the timeout counts as a success.
- FINISH: done=1 for exactly one cycle, then IDLE.
- busy = 1 in RD_WAIT, WR_WAIT and FINISH.
- While busy: rd_start, wr_start and mdrin are ignored.
- mem_ack outside the WAIT states is ignored.

Test Plan:
- Reset, then mdrin=1 with busmuxout=0xDEADBEEF → q=0xDEADBEEF next edge; busy=0, mem_req=0.
- Word read, addr_lo=00, memory acks after 3 wait cycles with 0x12345678:
  - mem_req is high for 4 cycles with mem_be=1111;
  - q=0x12345678, done pulses once, err=0.
- Byte read, addr_lo=10, mem_rdata=0x00A50000:
  - with sign_ext=1 → q=0xFFFFFFA5, mem_be=0100;
  - with sign_ext=0 → q=0x000000A5.
- Half write with q=0x0000BEEF, addr_lo=10 → mem_wdata=0xBEEFBEEF, mem_be=1100, mem_we=1; q is unchanged after ack.
- Misaligned word read (addr_lo=01) → no mem_req, err=1, done pulse. A memory that never acks → mem_req drops after TIMEOUT=15 cycles, err=1, q is unchanged.
- rd_start and wr_start together → read only, mem_we=0. Asserting clear in the middle of RD_WAIT → mem_req=0 and q=0 next edge; a late mem_ack afterwards is ignored.
